fixpoint_add_scheduler: RTL and testbench
=========================================

# fixpoint_add_scheduler

Round-robin scheduler that time-shares one W-bit fixed-point adder datapath among NREQ requesters, such as IIR filter sections contending for a single accumulate unit. Each requester presents an operand pair over a valid/ready handshake. The block arbitrates among them and registers the sum through a two-stage pipeline with backpressure. Each result is returned tagged with the requester ID, an overflow flag and optional saturation, and overflows are tallied in a saturating counter.

## Interface
- NREQ, 4, number of requesters; 2..8.
- WI, 1, integer bits of operands and result, sign bit included.
- WF, 15, fraction bits of operands and result; W = WI+WF.
- SAT, 1, 1 = saturate on overflow, 0 = two's-complement wrap.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  requester i has an operand pair pending.
- req_a  in  NREQ*W  operand A, requester i in bits [i*W +: W], signed Q(WI).(WF).
- req_b  in  NREQ*W  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot or zero; bit i high means requester i is granted this cycle.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
- rsp_data  out  W  sum, wrapped or saturated per SAT.
- rsp_ovf  out  1  the sum overflowed W bits.
- ovf_cnt  out  16  count of overflowed results delivered; saturates at 0xFFFF.

## Operation
- Transfer on requester i: req_valid[i] && req_ready[i] in the same cycle. Transfer on output: rsp_valid && rsp_ready.
- Round-robin pointer ptr, range 0..NREQ-1, reset 0.
  - Grant goes to the first i with req_valid[i], searching ptr, ptr+1, … modulo NREQ.
  - On each accepted transfer, ptr becomes granted index + 1, wrapping NREQ-1 to 0.
  - ptr does not change when no transfer occurs.
- req_ready[g] is asserted only for the granted index g, and only when stage S1 can load.
- S1 holds a_q, b_q, id_q and v1.
  - S1 loads when v1 == 0 or S1 advances.
  - S1 advances when v1 && (v2 == 0 || rsp_ready).
- Adder is combinational on S1: sum = a_q + b_q, wrapped to W bits.
  - ovf = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]).
- S2 holds rsp_data, rsp_id, rsp_ovf and v2 (drives rsp_valid).
  - S2 loads from S1 when S1 advances.
  - v2 clears when an output transfer occurs and S1 is not advancing.
  - Contents of S2 hold while rsp_valid && !rsp_ready.
- Saturation, SAT=1 and ovf=1:
  - a_q non-negative → rsp_data = 0 followed by W-1 ones (max).
  - a_q negative → rsp_data = 1 followed by W-1 zeros (min).
- SAT=0: rsp_data = sum. rsp_ovf reports overflow in both modes.
- ovf_cnt increments by 1 on each output transfer with rsp_ovf=1. It holds at 0xFFFF once reached.
- Requesters must hold req_valid, req_a and req_b stable until their transfer. A requester that deasserts early simply loses the grant; no error is flagged.

## Timing
- Reset, synchronous: v1=0, v2=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, ovf_cnt=0, ptr=0. req_ready=0 during the reset cycle.
- Latency: request accepted at edge n → rsp_valid=1 after edge n+1 (2 cycles).
- Throughput: 1 result per cycle while rsp_ready=1.
- Backpressure:
  - With rsp_ready=0, at most 2 pairs are in flight (one in S1, one in S2); req_ready is then all 0.
  - When rsp_ready rises, S2 drains, S1 advances and a new grant is issued in the same cycle.
- Simultaneous S2 drain, S1 advance and new accept: all three occur in one cycle; no bubble, no loss.
- Reset mid-operation: in-flight S1/S2 contents are discarded and rsp_valid drops after the reset edge. ovf_cnt clears and ptr returns to 0.
- req_ready depends combinationally on req_valid, rsp_ready and internal state. rsp_* outputs are registered only.

## Test plan
- Basic sum, SAT=1: requester 0 sends a=0x4000, b=0x2000 → 2 cycles later rsp_valid=1, rsp_data=0x6000, rsp_id=0, rsp_ovf=0.
- Overflow: requester 2 sends 0x7000+0x2000 → SAT=1 gives 0x7FFF, SAT=0 gives 0x9000; rsp_ovf=1 and ovf_cnt=1. Then 0x8000+0x8000 → SAT=1 gives 0x8000, SAT=0 gives 0x0000; rsp_ovf=1 and ovf_cnt=2.
- Fairness: all 4 requesters hold valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,…; rsp_id follows the same sequence with one result per cycle.
- Backpressure: 3 requests queued, rsp_ready=0 for 5 cycles → only 2 accepted and rsp_data stays stable. Then rsp_ready=1 → remaining results arrive in order with no drop or duplicate.
- Reset mid-flight: RST=1 for 1 cycle while v1=v2=1 → next cycle rsp_valid=0, ovf_cnt=0. The next grant goes to the lowest valid index starting from 0.
- Counter saturation: force 65537 overflowing transfers → ovf_cnt=0xFFFF and stays there.

Source files
------------

// File: rtl/fixpoint_add_scheduler.sv
// fixpoint_add_scheduler: round-robin arbiter feeding one shared W-bit
// fixed-point adder. S1 latches the granted operand pair. S2 holds the
// registered sum, which is wrapped or saturated. Both stages stall under
// backpressure.
module fixpoint_add_scheduler #(
  parameter  int NREQ = 4,
  parameter  int WI   = 1,
  parameter  int WF   = 15,
  parameter  int SAT  = 1,
  localparam int W    = WI + WF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*W-1:0]      req_a,
  input  logic [NREQ*W-1:0]      req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [W-1:0]           rsp_data,
  output logic                   rsp_ovf,
  output logic [15:0]            ovf_cnt
);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } s1_t;

  // Per-requester operand view; same bit layout as the flat ports.
  logic [NREQ-1:0][W-1:0] a_arr, b_arr;
  assign a_arr = req_a;
  assign b_arr = req_b;

  logic [IDW-1:0] ptr;
  logic           v1, v2;
  s1_t            s1;

  logic           s1_adv, s1_load, accept, gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [W-1:0]   sum, sat_val, res;
  logic           ovf;

  // Index k steps past the pointer, modulo NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign s1_adv  = v1 && (!v2 || rsp_ready);
  assign s1_load = !v1 || s1_adv;

  // Round-robin search: the first valid requester at or after ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && req_valid[rr_idx(ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(ptr, k);
      end
    end
  end

  assign accept = gnt_found && s1_load && !RST;

  // One-hot ready to the winner, only when S1 can take the pair.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  // Pointer moves just past the index that was actually served.
  always_ff @(posedge CLK) begin
    if (RST)
      ptr <= '0;
    else if (accept)
      ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // S1: operand register, refilled whenever it is empty or moving on.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (s1_load) begin
      v1 <= accept;
      if (accept) s1 <= '{id: gnt_idx, a: a_arr[gnt_idx], b: b_arr[gnt_idx]};
    end
  end

  // Shared adder. Overflow occurs when the operands agree in sign and the
  // sum does not.
  assign sum     = s1.a + s1.b;
  assign ovf     = (s1.a[W-1] == s1.b[W-1]) && (sum[W-1] != s1.a[W-1]);
  assign sat_val = s1.a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  assign res     = (SAT != 0 && ovf) ? sat_val : sum;

  // S2: result register. It holds while the consumer stalls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      v2       <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_ovf  <= 1'b0;
    end else if (s1_adv) begin
      v2       <= 1'b1;
      rsp_data <= res;
      rsp_id   <= s1.id;
      rsp_ovf  <= ovf;
    end else if (v2 && rsp_ready) begin
      v2 <= 1'b0;
    end
  end

  assign rsp_valid = v2;

  // Count delivered overflowed results. The count sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (RST)
      ovf_cnt <= '0;
    else if (v2 && rsp_ready && rsp_ovf && ovf_cnt != 16'hFFFF)
      ovf_cnt <= ovf_cnt + 16'd1;
  end

endmodule

// File: tb/tb_fixpoint_add_scheduler.sv
// Bench for fixpoint_add_scheduler. A saturating instance and a wrapping
// instance share the same stimulus. A transaction-level scoreboard
// predicts the grant, the occupancy and the in-order results.
module tb_fixpoint_add_scheduler;
  localparam int NREQ = 4, WI = 1, WF = 15, W = WI + WF, IDW = 2;
  localparam int MAXV = (1 << (W-1)) - 1, MINV = -(1 << (W-1));

  logic CLK = 1'b0;
  logic RST;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a, req_b;
  logic              rsp_ready;
  logic [NREQ-1:0]   rdy_s, rdy_w;
  logic              vld_s, vld_w, ovf_s, ovf_w;
  logic [IDW-1:0]    id_s, id_w;
  logic [W-1:0]      data_s, data_w;
  logic [15:0]       cnt_s, cnt_w;

  always #5 CLK = ~CLK;

  fixpoint_add_scheduler #(.NREQ(NREQ), .WI(WI), .WF(WF), .SAT(1)) dut_s (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy_s), .rsp_valid(vld_s), .rsp_ready(rsp_ready), .rsp_id(id_s),
    .rsp_data(data_s), .rsp_ovf(ovf_s), .ovf_cnt(cnt_s));

  fixpoint_add_scheduler #(.NREQ(NREQ), .WI(WI), .WF(WF), .SAT(0)) dut_w (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy_w), .rsp_valid(vld_w), .rsp_ready(rsp_ready), .rsp_id(id_w),
    .rsp_data(data_w), .rsp_ovf(ovf_w), .ovf_cnt(cnt_w));

  typedef struct {
    int           id;
    logic [W-1:0] sat;
    logic [W-1:0] wrap;
    bit           ovf;
    int           acc;
  } item_t;

  typedef struct {
    int           id;
    logic [W-1:0] a, b, sat, wrap;
    bit           ovf;
    int           cnt;
  } tv_t;

  item_t mq[$];
  int mptr = 0, mcnt = 0, cyc = 0, ndeliv = 0, last_g = -1;
  int nvec = 0, nerr = 0;
  logic [NREQ-1:0] acc_mask;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference sum from plain integer arithmetic.
  function automatic item_t mk(int id, logic [W-1:0] a, logic [W-1:0] b, int acc);
    item_t it;
    int s;
    s = int'($signed(a)) + int'($signed(b));
    it.id   = id;
    it.acc  = acc;
    it.ovf  = (s > MAXV) || (s < MINV);
    it.wrap = W'(s);
    it.sat  = (s > MAXV) ? W'(MAXV) : (s < MINV) ? W'(MINV) : W'(s);
    return it;
  endfunction

  // Check outputs against the scoreboard, advance the model, then clock once.
  task automatic tick();
    logic [NREQ-1:0] exp_rdy;
    bit found, exp_v;
    int g;
    item_t h;
    acc_mask = '0;
    last_g   = -1;
    #1;
    exp_rdy = '0; found = 0; g = 0;
    if (!RST && (mq.size() < 2 || rsp_ready))
      for (int k = 0; k < NREQ; k++)
        if (!found && req_valid[(mptr + k) % NREQ]) begin
          found = 1; g = (mptr + k) % NREQ;
        end
    if (found) exp_rdy[g] = 1'b1;
    exp_v = (mq.size() > 0) && (cyc > mq[0].acc);
    chk("req_ready_sat",  32'(rdy_s), 32'(exp_rdy));
    chk("req_ready_wrap", 32'(rdy_w), 32'(exp_rdy));
    chk("rsp_valid_sat",  32'(vld_s), 32'(exp_v));
    chk("rsp_valid_wrap", 32'(vld_w), 32'(exp_v));
    chk("ovf_cnt_sat",    32'(cnt_s), 32'(mcnt));
    chk("ovf_cnt_wrap",   32'(cnt_w), 32'(mcnt));
    if (exp_v) begin
      h = mq[0];
      chk("rsp_data_sat",  32'(data_s), 32'(h.sat));
      chk("rsp_data_wrap", 32'(data_w), 32'(h.wrap));
      chk("rsp_id_sat",    32'(id_s),   32'(h.id));
      chk("rsp_id_wrap",   32'(id_w),   32'(h.id));
      chk("rsp_ovf_sat",   32'(ovf_s),  32'(h.ovf));
      chk("rsp_ovf_wrap",  32'(ovf_w),  32'(h.ovf));
    end
    if (RST) begin
      mq.delete(); mptr = 0; mcnt = 0;
    end else begin
      if (exp_v && rsp_ready) begin
        h = mq.pop_front();
        ndeliv++;
        if (h.ovf && mcnt < 65535) mcnt++;
      end
      if (found) begin
        mq.push_back(mk(g, req_a[g*W +: W], req_b[g*W +: W], cyc + 1));
        mptr = (g + 1) % NREQ;
        acc_mask[g] = 1'b1;
        last_g = g;
      end
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    RST = 1'b1; req_valid = '0;
    tick();
    RST = 1'b0;
  endtask

  task automatic drain();
    int n;
    req_valid = '0; rsp_ready = 1'b1; n = 0;
    while (mq.size() > 0 && n < 10) begin tick(); n++; end
    chk("drain_empty", 32'(vld_s), 32'(0));
  endtask

  tv_t tv[7];
  int n, acc_n, d0;
  logic [W-1:0] held;

  initial begin
    tv[0] = '{0, 16'h4000, 16'h2000, 16'h6000, 16'h6000, 1'b0, 0};
    tv[1] = '{2, 16'h7000, 16'h2000, 16'h7FFF, 16'h9000, 1'b1, 1};
    tv[2] = '{2, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b1, 2};
    tv[3] = '{1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 2};
    tv[4] = '{3, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF, 1'b0, 2};
    tv[5] = '{3, 16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b1, 3};
    tv[6] = '{1, 16'hC000, 16'hC000, 16'h8000, 16'h8000, 1'b0, 3};

    RST = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1; RST = 1'b0;
    #1;
    chk("reset_valid", 32'(vld_s),  32'(0));
    chk("reset_data",  32'(data_s), 32'(0));
    chk("reset_id",    32'(id_s),   32'(0));
    chk("reset_ovf",   32'(ovf_s),  32'(0));
    chk("reset_cnt",   32'(cnt_w),  32'(0));
    chk("reset_ready", 32'(rdy_s),  32'(0));

    // Directed vectors: single request, exact latency, both SAT modes.
    foreach (tv[e]) begin
      req_valid = '0; rsp_ready = 1'b1;
      set_req(tv[e].id, tv[e].a, tv[e].b);
      n = 0;
      do begin tick(); n++; end while (!acc_mask[tv[e].id] && n < 10);
      chk("tv_accept", 32'(acc_mask[tv[e].id]), 32'(1));
      req_valid = '0;
      chk("tv_latency", 32'(vld_s), 32'(0));
      tick();
      chk("tv_valid",     32'(vld_s),  32'(1));
      chk("tv_data_sat",  32'(data_s), 32'(tv[e].sat));
      chk("tv_data_wrap", 32'(data_w), 32'(tv[e].wrap));
      chk("tv_id",        32'(id_s),   32'(tv[e].id));
      chk("tv_ovf",       32'(ovf_w),  32'(tv[e].ovf));
      tick();
      chk("tv_cnt", 32'(cnt_s), 32'(tv[e].cnt));
    end

    // Fairness: all requesters valid, one grant per cycle in rotation.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, W'(i * 16'h0100), 16'h0010);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("fair_gnt", 32'(last_g), 32'(k % NREQ));
    end
    drain();

    // Backpressure: three requesters queued behind a stalled consumer.
    do_reset();
    rsp_ready = 1'b0; acc_n = 0; held = '0;
    set_req(0, 16'h1000, 16'h0234);
    set_req(1, 16'h2000, 16'h0345);
    set_req(2, 16'h3000, 16'h0456);
    for (int k = 0; k < 5; k++) begin
      tick();
      acc_n += $countones(acc_mask);
      req_valid &= ~acc_mask;
      if (k == 2) held = data_s;
    end
    chk("bp_accepted", 32'(acc_n), 32'(2));
    chk("bp_stable",   32'(data_s), 32'(held));
    chk("bp_ready_low", 32'(rdy_s), 32'(0));
    rsp_ready = 1'b1; d0 = ndeliv; n = 0;
    while ((mq.size() > 0 || req_valid != '0) && n < 12) begin
      tick(); req_valid &= ~acc_mask; n++;
    end
    chk("bp_delivered", 32'(ndeliv - d0), 32'(3));

    // Reset with both stages full.
    rsp_ready = 1'b1;
    set_req(0, 16'h7000, 16'h2000);
    tick(); req_valid = '0;
    drain();
    chk("mid_cnt_before", 32'(cnt_s), 32'(1));
    rsp_ready = 1'b0;
    set_req(1, 16'h0100, 16'h0100);
    set_req(3, 16'h0200, 16'h0200);
    n = 0;
    while (req_valid != '0 && n < 6) begin tick(); req_valid &= ~acc_mask; n++; end
    tick();
    chk("mid_full_valid", 32'(vld_s), 32'(1));
    chk("mid_full_ready", 32'(rdy_s), 32'(0));
    RST = 1'b1; tick(); RST = 1'b0;
    chk("mid_rst_valid", 32'(vld_s), 32'(0));
    chk("mid_rst_cnt",   32'(cnt_s), 32'(0));
    rsp_ready = 1'b1;
    set_req(1, 16'h0100, 16'h0100);
    set_req(3, 16'h0200, 16'h0200);
    #1;
    chk("mid_first_gnt", 32'(rdy_s), 32'(4'b0010));
    n = 0;
    while ((mq.size() > 0 || req_valid != '0) && n < 12) begin
      tick(); req_valid &= ~acc_mask; n++;
    end

    // Random traffic with random backpressure and occasional reset.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(2) == 0)
          set_req(i, W'($urandom), W'($urandom));
      rsp_ready = ($urandom_range(3) != 0);
      RST = ($urandom_range(399) == 0);
      tick();
      RST = 1'b0;
      req_valid &= ~acc_mask;
    end
    drain();

    // Counter saturation: back-to-back overflowing sums.
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 16'h7000, 16'h2000);
    repeat (65545) tick();
    chk("sat_cnt", 32'(cnt_s), 32'(16'hFFFF));
    repeat (5) tick();
    chk("sat_cnt_hold", 32'(cnt_w), 32'(16'hFFFF));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
